// File: rtl/ibus_sram_arb_if.sv
// Bus bundle between the two instruction-SRAM requesters, the arbiter and
// the raw SRAM pins. The arbiter attaches through the slave modport; the
// requester/SRAM side attaches through the master modport.
interface ibus_sram_arb_if #(
  parameter int unsigned SRAM_ADDR_WIDTH = 13,
  parameter int unsigned SRAM_DATA_WIDTH = 32
);
  // Port A: instruction fetch / APB-to-SRAM
  logic                       a_req;
  logic [3:0]                 a_we;
  logic [SRAM_ADDR_WIDTH-3:0] a_addr;
  logic [SRAM_DATA_WIDTH-1:0] a_wdata;
  logic                       a_gnt;
  logic                       a_rvalid;
  logic [SRAM_DATA_WIDTH-1:0] a_rdata;
  // Port B: loader / debug
  logic                       b_req;
  logic [3:0]                 b_we;
  logic [SRAM_ADDR_WIDTH-3:0] b_addr;
  logic [SRAM_DATA_WIDTH-1:0] b_wdata;
  logic                       b_gnt;
  logic                       b_rvalid;
  logic [SRAM_DATA_WIDTH-1:0] b_rdata;
  // SRAM pins
  logic                       mem_cen;
  logic [3:0]                 mem_wen;
  logic [SRAM_ADDR_WIDTH-3:0] mem_addr;
  logic [SRAM_DATA_WIDTH-1:0] mem_wdata;
  logic [SRAM_DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_cen, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_cen, mem_wen, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ibus_sram_arb.sv
// Two-requester arbiter for the single-port instruction SRAM.
// Port A has fixed priority; one access is granted per cycle and read data
// returns to the owning port one cycle after the grant.
// Optional starvation guard for port B: define IBUS_SRAM_ARB_STARVE_EN.
module ibus_sram_arb #(
  parameter int unsigned SRAM_ADDR_WIDTH = 13,
  parameter int unsigned SRAM_DATA_WIDTH = 32,
  parameter int unsigned STARVE_MAX      = 4
) (
  input  logic           HCLK,
  input  logic           HRESET,
  ibus_sram_arb_if.slave bus
);
  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("STARVE_MAX must be in 1..255");
  end

  logic                       w_force_b;
  logic                       w_a_win;
  logic                       w_b_win;
  logic                       w_rd_issue;
  logic [SRAM_ADDR_WIDTH-3:0] w_addr;
  logic [SRAM_DATA_WIDTH-1:0] w_wdata;
  logic                       r_rd_pend;
  owner_t                     r_rd_owner;

`ifdef IBUS_SRAM_ARB_STARVE_EN
  logic [7:0] r_starve_cnt;

  // B is forced through once it has been denied STARVE_MAX cycles in a row
  always_comb w_force_b = (r_starve_cnt == 8'(STARVE_MAX));

  // Count consecutive denied B cycles, saturating; clear on grant or idle
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_starve_cnt <= '0;
    end else if (!bus.b_req || w_b_win) begin
      r_starve_cnt <= '0;
    end else if (!w_force_b) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end
`else
  // Pure fixed priority: B never forced
  always_comb w_force_b = 1'b0;
`endif

  // Winner selection and SRAM pin drive; no grants while in reset
  always_comb begin
    w_a_win    = bus.a_req && !(w_force_b && bus.b_req) && !HRESET;
    w_b_win    = bus.b_req && (!bus.a_req || w_force_b) && !HRESET;
    w_addr     = w_b_win ? bus.b_addr  : bus.a_addr;
    w_wdata    = w_b_win ? bus.b_wdata : bus.a_wdata;
    w_rd_issue = (w_a_win && (bus.a_we == 4'b0000)) ||
                 (w_b_win && (bus.b_we == 4'b0000));

    bus.a_gnt     = w_a_win;
    bus.b_gnt     = w_b_win;
    bus.mem_cen   = !(w_a_win || w_b_win);
    bus.mem_wen   = w_a_win ? ~bus.a_we : (w_b_win ? ~bus.b_we : '1);
    bus.mem_addr  = w_addr;
    bus.mem_wdata = w_wdata;
  end

  // Remember which port issued the read so its data can be routed next cycle
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= OWN_A;
    end else begin
      r_rd_pend <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_owner <= w_b_win ? OWN_B : OWN_A;
      end
    end
  end

  // Return read data to its owner; rvalid is also suppressed during reset so
  // a read granted just before reset never reports completion
  always_comb begin
    bus.a_rvalid = r_rd_pend && (r_rd_owner == OWN_A) && !HRESET;
    bus.b_rvalid = r_rd_pend && (r_rd_owner == OWN_B) && !HRESET;
    bus.a_rdata  = bus.a_rvalid ? bus.mem_rdata : '0;
    bus.b_rdata  = bus.b_rvalid ? bus.mem_rdata : '0;
  end
endmodule
